// File: rtl/divider_controller_if.sv
// Handshake/status bundle between the divider controller (slave) and its
// datapath plus requester (master).
interface divider_controller_if;
  // Requests and datapath status into the controller
  logic start;
  logic dvz;
  logic ovf;
  logic Cout;
  // Datapath controls out of the controller
  logic sclr;
  logic Ld_A;
  logic Ld_B;
  logic Ld_Cnt;
  logic Ld_Q;
  logic Ld_Acc;
  logic cntEn;
  logic S1;
  // Status out of the controller
  logic ready;
  logic busy;
  logic done;
  logic dvz_err;
  logic ovf_err;
  logic tmo_err;

  // Handshake: start is only sampled while ready=1; a request is accepted on the
  // rising edge where ready=1 and start=1, and completes with a one-cycle done
  // pulse (error flags valid from done until the next accepted start).
  modport master (
    output start, dvz, ovf, Cout,
    input  sclr, Ld_A, Ld_B, Ld_Cnt, Ld_Q, Ld_Acc, cntEn, S1,
    input  ready, busy, done, dvz_err, ovf_err, tmo_err
  );

  modport slave (
    input  start, dvz, ovf, Cout,
    output sclr, Ld_A, Ld_B, Ld_Cnt, Ld_Q, Ld_Acc, cntEn, S1,
    output ready, busy, done, dvz_err, ovf_err, tmo_err
  );
endinterface

// File: rtl/divider_controller.sv
// Moore sequencer for a counter-driven iterative divider datapath.
// Optional CALC watchdog with ABORT state: define DIVCTL_TIMEOUT_EN.
module divider_controller #(
  parameter int MAX_CALC_CYCLES = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  divider_controller_if.slave  bus,
  output logic [2:0]           o_state
);

`ifdef DIVCTL_TIMEOUT_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CALC  = 3'd2,
    S_DONE  = 3'd3,
    S_ABORT = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_CALC = 3'd2,
    S_DONE = 3'd3
  } state_t;
`endif

  state_t r_state;
  state_t w_next_state;

  logic r_dvz_err;
  logic r_ovf_err;
  logic w_dvz_nxt;
  logic w_ovf_nxt;

  logic w_ready;
  logic w_busy;
  logic w_done;
  logic w_abort;
  logic w_ld_a;
  logic w_ld_b;
  logic w_ld_cnt;
  logic w_ld_q;
  logic w_ld_acc;
  logic w_cnt_en;
  logic w_s1;

`ifdef DIVCTL_TIMEOUT_EN
  localparam int CW = $clog2(MAX_CALC_CYCLES + 1);
  localparam logic [CW-1:0] LP_LAST_CALC = CW'(MAX_CALC_CYCLES - 1);

  logic [CW-1:0] r_calc_cnt;
  logic          r_tmo_err;
  logic          w_tmo_nxt;
`else
  // Keeps the watchdog parameter referenced when the watchdog is compiled out.
  logic w_unused_max;
  assign w_unused_max = (MAX_CALC_CYCLES > 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_dvz_err <= 1'b0;
      r_ovf_err <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_dvz_err <= w_dvz_nxt;
      r_ovf_err <= w_ovf_nxt;
    end
  end

`ifdef DIVCTL_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_calc_cnt <= '0;
      r_tmo_err  <= 1'b0;
    end else begin
      r_tmo_err <= w_tmo_nxt;
      if (w_next_state == S_LOAD) begin
        r_calc_cnt <= '0;
      end else if (r_state == S_CALC) begin
        r_calc_cnt <= r_calc_cnt + CW'(1);
      end
    end
  end
`endif

  always_comb begin
    w_next_state = r_state;
    w_dvz_nxt    = r_dvz_err;
    w_ovf_nxt    = r_ovf_err;
`ifdef DIVCTL_TIMEOUT_EN
    w_tmo_nxt    = r_tmo_err;
`endif
    w_ready  = 1'b0;
    w_busy   = 1'b0;
    w_done   = 1'b0;
    w_abort  = 1'b0;
    w_ld_a   = 1'b0;
    w_ld_b   = 1'b0;
    w_ld_cnt = 1'b0;
    w_ld_q   = 1'b0;
    w_ld_acc = 1'b0;
    w_cnt_en = 1'b0;
    w_s1     = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.start) begin
          w_dvz_nxt = 1'b0;
          w_ovf_nxt = 1'b0;
`ifdef DIVCTL_TIMEOUT_EN
          w_tmo_nxt = 1'b0;
`endif
          // A zero divisor never touches the datapath registers.
          if (bus.dvz) begin
            w_dvz_nxt    = 1'b1;
            w_next_state = S_DONE;
          end else begin
            w_next_state = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        w_busy       = 1'b1;
        w_ld_a       = 1'b1;
        w_ld_b       = 1'b1;
        w_ld_q       = 1'b1;
        w_ld_acc     = 1'b1;
        w_ld_cnt     = 1'b1;
        w_next_state = S_CALC;
      end

      S_CALC: begin
        w_busy = 1'b1;
        w_s1   = 1'b1;
        if (bus.Cout) begin
          w_next_state = S_DONE;
        end else begin
          w_ld_q   = 1'b1;
          w_ld_acc = 1'b1;
          w_cnt_en = 1'b1;
          if (bus.ovf) begin
            w_ovf_nxt = 1'b1;
          end
`ifdef DIVCTL_TIMEOUT_EN
          if (r_calc_cnt == LP_LAST_CALC) begin
            w_tmo_nxt    = 1'b1;
            w_next_state = S_ABORT;
          end
`endif
        end
      end

      S_DONE: begin
        w_done       = 1'b1;
        w_next_state = S_IDLE;
      end

`ifdef DIVCTL_TIMEOUT_EN
      S_ABORT: begin
        w_busy       = 1'b1;
        w_abort      = 1'b1;
        w_next_state = S_DONE;
      end
`endif

      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Reset overrides every load strobe so the datapath only sees the clear.
  assign bus.sclr   = rst | w_abort;
  assign bus.Ld_A   = w_ld_a   & ~rst;
  assign bus.Ld_B   = w_ld_b   & ~rst;
  assign bus.Ld_Cnt = w_ld_cnt & ~rst;
  assign bus.Ld_Q   = w_ld_q   & ~rst;
  assign bus.Ld_Acc = w_ld_acc & ~rst;
  assign bus.cntEn  = w_cnt_en & ~rst;
  assign bus.S1     = w_s1     & ~rst;

  assign bus.ready   = w_ready;
  assign bus.busy    = w_busy;
  assign bus.done    = w_done;
  assign bus.dvz_err = r_dvz_err;
  assign bus.ovf_err = r_ovf_err;
`ifdef DIVCTL_TIMEOUT_EN
  assign bus.tmo_err = r_tmo_err;
`else
  assign bus.tmo_err = 1'b0;
`endif

  assign o_state = r_state;

endmodule

// File: tb/tb_divider_controller.sv
// Bench for divider_controller: small divider datapath, cycle-timing model of
// the controller outputs, directed scenarios with literal expectations.
module tb_divider_controller;
  localparam int W = 14;

  localparam int PH_IDLE  = 0;
  localparam int PH_LOAD  = 1;
  localparam int PH_WORK  = 2;
  localparam int PH_TERM  = 3;
  localparam int PH_ABORT = 4;
  localparam int PH_DONE  = 5;

  localparam int K_NORM = 0;
  localparam int K_DVZ  = 1;
  localparam int K_TMO  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start     = 1'b0;
  logic       ovf_force = 1'b0;
  logic       cout_kill = 1'b0;
  logic [9:0] in_A      = 10'd0;
  logic [9:0] in_B      = 10'd1;
  logic [2:0] dbg_state;

  int checks   = 0;
  int failures = 0;

  divider_controller_if dif ();

  divider_controller #(.MAX_CALC_CYCLES(20)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (dif.slave),
    .o_state (dbg_state)
  );

  // ---------------- datapath: preload 2, terminal count 15 ----------------
  logic [4:0] dp_cnt;
  logic [9:0] dp_b;
  logic [9:0] dp_q;
  logic [9:0] dp_acc;

  always @(posedge clk) begin
    if (dif.sclr) begin
      dp_cnt <= 5'd0;
      dp_b   <= 10'd0;
      dp_q   <= 10'd0;
      dp_acc <= 10'd0;
    end else begin
      if (dif.Ld_Cnt) dp_cnt <= 5'd2;
      else if (dif.cntEn && dp_cnt != 5'd31) dp_cnt <= dp_cnt + 5'd1;
      if (dif.Ld_B) dp_b <= in_B;
      if (dif.Ld_Acc && !dif.S1) dp_acc <= in_A;
      else if (dif.Ld_Acc && dp_acc >= dp_b) dp_acc <= dp_acc - dp_b;
      if (dif.Ld_Q && !dif.S1) dp_q <= 10'd0;
      else if (dif.Ld_Q && dp_acc >= dp_b) dp_q <= dp_q + 10'd1;
    end
  end

  // Cout rises once the counter has stepped past terminal count 15.
  assign dif.start = start;
  assign dif.dvz   = (in_B == 10'd0);
  assign dif.ovf   = ovf_force;
  assign dif.Cout  = (dp_cnt > 5'd15) && !cout_kill;

  // ---------------- model: output pattern by cycles since acceptance ----------------
  logic [W-1:0] exp_q[$];

  function automatic int phase_of(input int kind, input int age);
    if (age < 0) return PH_IDLE;
    if (kind == K_DVZ) return PH_DONE;
    if (age == 1) return PH_LOAD;
    if (kind == K_TMO) begin
      if (age <= 21) return PH_WORK;
      if (age == 22) return PH_ABORT;
      return PH_DONE;
    end
    if (age <= 15) return PH_WORK;
    if (age == 16) return PH_TERM;
    return PH_DONE;
  endfunction

  function automatic logic [10:0] ctrl_of(input int ph);
    // {ready, busy, done, sclr, Ld_A, Ld_B, Ld_Cnt, Ld_Q, Ld_Acc, cntEn, S1}
    case (ph)
      PH_IDLE:  return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      PH_LOAD:  return {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      PH_WORK:  return {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      PH_TERM:  return {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      PH_ABORT: return {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      default:  return {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    endcase
  endfunction

  initial begin : model
    int  age  = -1;
    int  kind = K_NORM;
    int  ph;
    bit  f_dvz = 1'b0;
    bit  f_ovf = 1'b0;
    bit  f_tmo = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        age = -1;
        f_dvz = 1'b0; f_ovf = 1'b0; f_tmo = 1'b0;
      end else if (age < 0) begin
        if (start) begin
          kind  = (in_B == 10'd0) ? K_DVZ : (cout_kill ? K_TMO : K_NORM);
          f_dvz = (kind == K_DVZ);
          f_ovf = 1'b0;
          f_tmo = 1'b0;
          age   = 1;
        end
      end else begin
        ph = phase_of(kind, age);
        if (ph == PH_WORK && ovf_force) f_ovf = 1'b1;
        if (ph == PH_WORK && kind == K_TMO && age == 21) f_tmo = 1'b1;
        if (ph == PH_DONE) age = -1;
        else age = age + 1;
      end
      exp_q.push_back({ctrl_of(phase_of(kind, age)), f_dvz, f_ovf, f_tmo});
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  initial begin : compare
    logic [W-1:0] exp_w;
    logic [W-1:0] act_w;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_w = exp_q.pop_front();
        if (rst) exp_w[10:3] = 8'b1000_0000;
        act_w = {dif.ready, dif.busy, dif.done, dif.sclr, dif.Ld_A, dif.Ld_B,
                 dif.Ld_Cnt, dif.Ld_Q, dif.Ld_Acc, dif.cntEn, dif.S1,
                 dif.dvz_err, dif.ovf_err, dif.tmo_err};
        checks++;
        if (act_w !== exp_w) begin
          failures++;
          $display("FAIL cycle_outputs t=%0t state=%0d: got %b expected %b",
                   $time, dbg_state, act_w, exp_w);
        end
      end
    end
  end

  // ---------------- monitors for scenario literals ----------------
  bit ld_seen  = 1'b0;
  int sclr_cnt = 0;
  initial begin : monitors
    forever begin
      @(negedge clk);
      if (dif.Ld_A || dif.Ld_B || dif.Ld_Cnt || dif.Ld_Q || dif.Ld_Acc) ld_seen = 1'b1;
      if (dif.sclr && !rst) sclr_cnt++;
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Cycle 0 carries start=1; returns 1ns into cycle 1.
  task automatic start_pulse();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Returns at the negedge of the done cycle, cyc = its cycle number.
  task automatic wait_done(input int c0, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = c0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (dif.done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin : stim
    int cyc;
    int ndone;
    int d0;
    int d1;

    @(negedge clk);
    check("reset_sclr", dif.sclr, 1);
    check("reset_ld_a", dif.Ld_A, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_reset_ready", dif.ready, 1);
    check("post_reset_busy", dif.busy, 0);
    check("post_reset_done", dif.done, 0);
    check("post_reset_sclr", dif.sclr, 0);

    // 100 / 7
    in_A = 10'd100; in_B = 10'd7;
    start_pulse();
    wait_done(1, cyc);
    check("div_done_cycle", cyc, 17);
    check("div_quotient", dp_q, 14);
    check("div_flags", {dif.dvz_err, dif.ovf_err, dif.tmo_err}, 0);

    // divide by zero
    in_B = 10'd0;
    ld_seen = 1'b0;
    start_pulse();
    wait_done(1, cyc);
    check("dvz_done_cycle", cyc, 1);
    check("dvz_err_set", dif.dvz_err, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("dvz_ready_cycle2", dif.ready, 1);
    check("dvz_no_loads", ld_seen, 0);
    check("dvz_err_held", dif.dvz_err, 1);

    // overflow reported, then cleared by next start
    in_A = 10'd1023; in_B = 10'd1; ovf_force = 1'b1;
    start_pulse();
    wait_done(1, cyc);
    check("ovf_err_set", dif.ovf_err, 1);
    check("ovf_dvz_clear", dif.dvz_err, 0);
    ovf_force = 1'b0; in_A = 10'd100; in_B = 10'd7;
    start_pulse();
    @(negedge clk);
    check("ovf_err_cleared", dif.ovf_err, 0);
    wait_done(2, cyc);
    check("ovf_next_done_cycle", cyc, 17);

    // reset in CALC cycle 8
    ovf_force = 1'b1;
    start_pulse();
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    check("midrst_sclr", dif.sclr, 1);
    check("midrst_ld_q", dif.Ld_Q, 0);
    check("midrst_ovf_before", dif.ovf_err, 1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_ready", dif.ready, 1);
    check("midrst_ovf_cleared", dif.ovf_err, 0);
    ovf_force = 1'b0;
    start_pulse();
    wait_done(1, cyc);
    check("midrst_fresh_done_cycle", cyc, 17);
    check("midrst_fresh_quotient", dp_q, 14);

    // start held high for 40 cycles
    ndone = 0; d0 = 0; d1 = 0;
    @(posedge clk); #1 start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (dif.done) begin
        if (ndone == 0) d0 = c;
        else if (ndone == 1) d1 = c;
        ndone++;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("held_done_count", ndone, 2);
    check("held_first_done", d0, 17);
    check("held_done_spacing", d1 - d0, 18);
    wait_done(40, cyc);
    check("held_third_done", cyc, 53);

`ifdef DIVCTL_TIMEOUT_EN
    cout_kill = 1'b1;
    sclr_cnt  = 0;
    start_pulse();
    wait_done(1, cyc);
    check("tmo_done_cycle", cyc, 23);
    check("tmo_err_set", dif.tmo_err, 1);
    check("tmo_sclr_cycles", sclr_cnt, 1);
    cout_kill = 1'b0;
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
